deconv_engine: RTL and testbench
================================

DECONV_ENGINE -- requirements
Module: deconv_engine

Interface
REQ-001 SHALL have parameter N, default 8, giving the number of kernel taps and recovered samples.
REQ-002 SHALL have parameter Y_LEN, default 16, giving the number of convolution-result samples accepted per frame.
REQ-003 SHALL have parameter ACC_W, default 20, giving the signed accumulator and dividend width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts a beat; a beat transfers when in_valid && in_ready at a clock edge.
REQ-008 SHALL have port in_data, input, 16 bits, signed: kernel beats use [7:0] with [15:8] ignored; y beats use all 16 bits.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream accepts a beat.
REQ-011 SHALL have port out_data, output, 8 bits, signed: recovered sample x[n].
REQ-012 SHALL have port out_last, output, 1 bit: marks beat x[N-1].
REQ-013 SHALL have port err_code, output, 2 bits: frame status, valid while out_valid && out_last; 0 = ok, 1 = h0 zero, 2 = inexact, 3 = overflow.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL accept, per frame, N kernel beats h[0..N-1] followed by Y_LEN beats y[0..Y_LEN-1], then recover x[0..N-1] such that y = x * h (convolution).
REQ-016 SHALL use states IDLE -> LOAD_H -> LOAD_Y -> MAC -> DIV -> (MAC | EMIT) -> IDLE.
- IDLE leaves to LOAD_H on the first in_valid, and that beat is h[0].
REQ-017 SHALL assert in_ready only in IDLE, LOAD_H and LOAD_Y.
REQ-018 SHALL accept y[N..Y_LEN-1] and discard them; no consistency check is performed on these samples.
REQ-019 SHALL compute, for n = 0..N-1:
- acc = sext(y[n]) - sum over k = 1..min(n, N-1) of h[k]*x[n-k], all in ACC_W-bit signed arithmetic;
- MAC spends exactly n cycles, one product per cycle; n = 0 skips MAC.
REQ-020 SHALL divide acc by h[0] in DIV, which takes exactly ACC_W+1 cycles (1 load + ACC_W iterations):
- quotient truncates toward zero;
- x[n] is written on the final DIV cycle.
REQ-021 SHALL, on quotient overflow (outside -128..127), saturate x[n] to -128 or 127 and set the overflow flag.
REQ-022 SHALL, when the remainder is non-zero, set the inexact flag and keep the truncated quotient.
REQ-023 SHALL use the saturated or truncated x[n] for all later samples of the frame.
REQ-024 SHALL, when h[0] == 0 at LOAD_Y exit, skip MAC/DIV, set all x to 0, and enter EMIT on the next cycle.
REQ-025 SHALL assert the first out_valid exactly 196 cycles (sum over n of (n + 21)) after the edge accepting y[Y_LEN-1], or exactly 1 cycle after that edge when h[0] == 0.
REQ-026 SHALL, in EMIT, present x[0..N-1] in order:
- out_data/out_last are held stable while out_valid && !out_ready;
- there are no gaps between beats when out_ready is high;
- the state returns to IDLE on the edge accepting out_last.
REQ-027 SHALL report err_code by priority h0-zero > overflow > inexact; the flags are sticky per frame and cleared on IDLE exit.
REQ-028 SHALL NOT accept a new frame while in EMIT (in_ready low); a new frame may start on the cycle after IDLE is re-entered.

Reset
REQ-029 SHALL, when rst_n is low at a clock edge, force state = IDLE; in_ready = 1, out_valid = 0, out_data = 0, out_last = 0, err_code = 0, busy = 0, and clear counters and flags.
REQ-030 SHALL, on reset mid-frame (any state), abandon the frame without emitting a partial output; no stale x survives to the next frame.

Structure
REQ-031 SHALL place the state enum, N/Y_LEN/ACC_W defaults and the err_code constants in shared package deconv_pkg.
REQ-032 SHALL implement the divider as sub-module serial_sdiv:
- ACC_W-bit signed dividend, 8-bit signed divisor;
- start/done handshake, quotient, remainder;
- restoring, one bit per cycle.
REQ-033 SHALL use a single multiplier (8x8 -> 16 signed) shared across MAC cycles.

Verification
REQ-034 SHALL cover: h = {1,0,0,0,0,0,0,0}, y = {5,-3,7,0,...} -> x = {5,-3,7,0,0,0,0,0}, err_code = 0, first out_valid 196 cycles after the last y beat.
REQ-035 SHALL cover: h = {2,1,0,...}, y = {2,5,8,11,14,17,20,23,8,0,...} -> x = {1,2,3,4,5,6,7,8}, err_code = 0.
REQ-036 SHALL cover: h[0] = 0, any y -> eight zeros, err_code = 1, out_valid 1 cycle after the last y beat.
REQ-037 SHALL cover: h = {2,0,...}, y[0] = 3, rest 0 -> x[0] = 1, err_code = 2; and h = {1,0,...}, y[0] = 200 -> x[0] = 127, err_code = 3.
REQ-038 SHALL cover: case REQ-035 with out_ready toggled every other cycle -> identical sequence, data held stable while stalled, out_last on x[7] only.
REQ-039 SHALL cover: rst_n low during MAC of n = 4 -> IDLE next cycle, no out_valid; the following clean frame produces correct output.

Source files
------------

// File: rtl/deconv_pkg.sv
// Shared types and constants for the deconvolution engine and its serial divider.
package deconv_pkg;
  localparam int N_DEF     = 8;
  localparam int Y_LEN_DEF = 16;
  localparam int ACC_W_DEF = 20;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_H, S_LOAD_Y, S_MAC, S_DIV, S_EMIT
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_H0      = 2'd1;
  localparam logic [1:0] ERR_INEXACT = 2'd2;
  localparam logic [1:0] ERR_OVF     = 2'd3;
endpackage

// File: rtl/deconv_engine_sdiv.sv
// Restoring signed divider: one load cycle, then one quotient bit per cycle.
// Results are combinational during the final iteration cycle, flagged by done.
module serial_sdiv
  import deconv_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [ACC_W-1:0] dividend,
  input  logic signed [7:0]       divisor,
  output logic                    done,
  output logic signed [ACC_W:0]   quotient,
  output logic signed [7:0]       remainder
);
  localparam int CNT_W = $clog2(ACC_W + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [ACC_W-1:0] r_q;
  logic [7:0]       r_rem;
  logic [7:0]       r_dvs;
  logic             r_qneg;
  logic             r_rneg;

  logic [8:0]              w_trial;
  logic [7:0]              w_diff;
  logic                    w_ge;
  logic [7:0]              w_rem_nxt;
  logic [ACC_W-1:0]        w_q_nxt;
  logic signed [ACC_W:0]   w_qmag;
  logic signed [7:0]       w_rmag;

  // Partial remainder stays below |divisor| <= 128, so 8 bits hold it.
  assign w_trial   = {r_rem, r_q[ACC_W-1]};
  assign w_ge      = (w_trial >= {1'b0, r_dvs});
  assign w_diff    = w_trial[7:0] - r_dvs;
  assign w_rem_nxt = w_ge ? w_diff : w_trial[7:0];
  assign w_q_nxt   = {r_q[ACC_W-2:0], w_ge};
  assign w_qmag    = {1'b0, w_q_nxt};
  assign w_rmag    = w_rem_nxt;

  assign done      = r_busy && (r_cnt == CNT_W'(1));
  assign quotient  = r_qneg ? -w_qmag : w_qmag;
  assign remainder = r_rneg ? -w_rmag : w_rmag;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= CNT_W'(ACC_W);
    end else if (r_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      r_q    <= dividend[ACC_W-1] ? -dividend : dividend;
      r_dvs  <= divisor[7] ? -divisor : divisor;
      r_rem  <= '0;
      r_qneg <= dividend[ACC_W-1] ^ divisor[7];
      r_rneg <= dividend[ACC_W-1];
    end else if (r_busy) begin
      r_q   <= w_q_nxt;
      r_rem <= w_rem_nxt;
    end
  end
endmodule

// File: rtl/deconv_engine.sv
// Frame-based deconvolution: loads kernel h and result y, recovers x by
// forward substitution (shared MAC, then serial divide by h[0]) and streams x out.
module deconv_engine
  import deconv_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int Y_LEN = Y_LEN_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [7:0]  out_data,
  output logic               out_last,
  output logic [1:0]         err_code,
  output logic               busy
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(Y_LEN + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] LAST_H   = CW'(N - 1);
  localparam logic [CW-1:0] LAST_Y   = CW'(Y_LEN - 1);

  state_t r_state, w_next;

  logic signed [7:0]       r_h [N];
  logic signed [15:0]      r_y [N];
  logic signed [7:0]       r_x [N];
  logic signed [ACC_W-1:0] r_acc;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_n, r_k, r_idx;
  logic                    r_div_go;
  logic                    r_f_h0, r_f_ovf, r_f_inx;

  logic                    w_in_fire, w_out_fire, w_h_last, w_y_last;
  logic                    w_div_start, w_div_done, w_q_ovf;
  logic signed [ACC_W:0]   w_quot;
  logic signed [7:0]       w_rem;
  logic [IW-1:0]           w_xi, w_n_inc;
  logic signed [15:0]      w_prod;
  logic signed [ACC_W-1:0] w_prod_ext, w_y_next;

  function automatic logic signed [7:0] sat8(input logic signed [ACC_W:0] q);
    if (q > 127)       return 8'sd127;
    else if (q < -128) return -8'sd128;
    else               return q[7:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] sext16(input logic signed [15:0] v);
    return {{(ACC_W-16){v[15]}}, v};
  endfunction

  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = out_valid && out_ready;
  assign w_h_last    = (r_cnt == LAST_H);
  assign w_y_last    = (r_cnt == LAST_Y);
  assign w_xi        = r_n - r_k;
  assign w_n_inc     = r_n + IW'(1);
  assign w_prod      = 16'(r_h[r_k]) * 16'(r_x[w_xi]);
  assign w_prod_ext  = sext16(w_prod);
  assign w_y_next    = sext16(r_y[w_n_inc]);
  assign w_q_ovf     = (w_quot > 127) || (w_quot < -128);
  assign w_div_start = r_div_go && !r_f_h0;

  serial_sdiv #(.ACC_W(ACC_W)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_div_start),
    .dividend  (r_acc),
    .divisor   (r_h[0]),
    .done      (w_div_done),
    .quotient  (w_quot),
    .remainder (w_rem)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (in_valid) w_next = S_LOAD_H;
      S_LOAD_H: if (w_in_fire && w_h_last) w_next = S_LOAD_Y;
      S_LOAD_Y: if (w_in_fire && w_y_last) w_next = S_DIV;
      S_MAC:    if (r_k == r_n) w_next = S_DIV;
      S_DIV: begin
        if (r_f_h0)          w_next = S_EMIT;
        else if (w_div_done) w_next = (r_n == LAST_IDX) ? S_EMIT : S_MAC;
      end
      S_EMIT:   if (w_out_fire && (r_idx == LAST_IDX)) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE) || (r_state == S_LOAD_H) || (r_state == S_LOAD_Y);
    busy      = (r_state != S_IDLE);
    out_valid = (r_state == S_EMIT);
    out_data  = '0;
    out_last  = 1'b0;
    err_code  = ERR_OK;
    if (out_valid) begin
      out_data = r_x[r_idx];
      out_last = (r_idx == LAST_IDX);
      if (r_f_h0)       err_code = ERR_H0;
      else if (r_f_ovf) err_code = ERR_OVF;
      else if (r_f_inx) err_code = ERR_INEXACT;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_n      <= '0;
      r_k      <= '0;
      r_idx    <= '0;
      r_div_go <= 1'b0;
      r_f_h0   <= 1'b0;
      r_f_ovf  <= 1'b0;
      r_f_inx  <= 1'b0;
    end else begin
      r_div_go <= 1'b0;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_cnt   <= CW'(1);
          r_n     <= '0;
          r_k     <= '0;
          r_idx   <= '0;
          r_f_h0  <= 1'b0;
          r_f_ovf <= 1'b0;
          r_f_inx <= 1'b0;
        end
        S_LOAD_H: if (w_in_fire) r_cnt <= w_h_last ? '0 : r_cnt + CW'(1);
        S_LOAD_Y: if (w_in_fire) begin
          r_cnt <= r_cnt + CW'(1);
          if (w_y_last) begin
            r_f_h0   <= (r_h[0] == 8'sd0);
            r_div_go <= 1'b1;
          end
        end
        S_MAC: begin
          r_k <= r_k + IW'(1);
          if (r_k == r_n) r_div_go <= 1'b1;
        end
        S_DIV: if (!r_f_h0 && w_div_done) begin
          r_f_ovf <= r_f_ovf | w_q_ovf;
          r_f_inx <= r_f_inx | (w_rem != 8'sd0);
          r_n     <= w_n_inc;
          r_k     <= IW'(1);
        end
        S_EMIT: if (w_out_fire) r_idx <= r_idx + IW'(1);
        default: ;
      endcase
    end
  end

  // x is cleared on every frame start so an abandoned frame leaves nothing behind.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: if (in_valid) begin
        r_h[0] <= in_data[7:0];
        for (int i = 0; i < N; i++) r_x[i] <= '0;
      end
      S_LOAD_H: if (w_in_fire) r_h[r_cnt[IW-1:0]] <= in_data[7:0];
      S_LOAD_Y: if (w_in_fire) begin
        if (r_cnt < CW'(N)) r_y[r_cnt[IW-1:0]] <= in_data;
        if (w_y_last) r_acc <= sext16(r_y[0]);
      end
      S_MAC: r_acc <= r_acc - w_prod_ext;
      S_DIV: if (!r_f_h0 && w_div_done) begin
        r_x[r_n] <= sat8(w_quot);
        r_acc    <= w_y_next;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_deconv_engine.sv
// Scoreboard bench for deconv_engine: directed frames with hand-computed x,
// err_code and first-beat latency; a negedge monitor checks every output beat.
module tb_deconv_engine;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_data = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic signed [7:0]  out_data;
  logic               out_last;
  logic [1:0]         err_code;
  logic               busy;

  deconv_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct { int d; bit last; int err; } exp_t;
  exp_t sb[$];
  int   lq[$];

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  acc_cyc = 0;
  int  stall = 0;
  bit  frame_first = 1'b1;
  bit  rst_seen = 1'b0;
  bit  tog = 1'b0;

  logic signed [7:0]  h_v [8];
  logic signed [15:0] y_v [16];
  int                 x_v [8];

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst_n;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = tog ? ~out_ready : 1'b1;
    end
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor: compares every presented beat against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (rst_seen) begin
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_err_code", int'(err_code), 0);
      frame_first = 1'b1;
      stall = 0;
    end else begin
      if (out_valid === 1'b1) begin
        chk("in_ready_in_emit", int'(in_ready), 0);
        if (frame_first) begin
          if (lq.size() > 0) begin
            lat = lq.pop_front();
            chk("first_valid_latency", cyc - acc_cyc, lat);
          end
          frame_first = 1'b0;
        end
        if (sb.size() == 0) begin
          chk("unexpected_beat", int'(out_valid), 0);
        end else begin
          e = sb[0];
          chk("out_data", int'(out_data), e.d);
          chk("out_last", int'(out_last), int'(e.last));
          if (e.last) chk("err_code", int'(err_code), e.err);
          if (out_ready) begin
            void'(sb.pop_front());
            stall = -1;
            if (e.last) frame_first = 1'b1;
          end
        end
      end
      if (sb.size() > 0) begin
        stall++;
        if (stall > 800) begin
          chk("watchdog_pending_beats", sb.size(), 0);
          sb.delete();
          lq.delete();
          stall = 0;
        end
      end else begin
        stall = 0;
      end
    end
  end

  task automatic clr_vec();
    for (int i = 0; i < 8; i++) begin h_v[i] = '0; x_v[i] = 0; end
    for (int i = 0; i < 16; i++) y_v[i] = '0;
  endtask

  task automatic load_ramp();
    clr_vec();
    h_v[0] = 8'sd2;
    h_v[1] = 8'sd1;
    for (int i = 0; i < 8; i++) begin
      y_v[i] = 16'(2 + 3 * i);
      x_v[i] = i + 1;
    end
    y_v[8] = 16'sd8;
  endtask

  task automatic send(input logic [15:0] d);
    int w;
    in_valid = 1'b1;
    in_data  = d;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      $display("FAIL in_ready_timeout actual 0 required 1 (cycle %0d)", cyc);
      $fatal(1, "input handshake stuck");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int err, input int lat, input bit expect_out);
    int w;
    if (expect_out) begin
      for (int i = 0; i < 8; i++) sb.push_back('{x_v[i], (i == 7), err});
      lq.push_back(lat);
    end
    // Upper byte of kernel beats carries junk that must be ignored.
    for (int i = 0; i < 8; i++) send({8'hA5, h_v[i]});
    for (int i = 0; i < 16; i++) send(y_v[i]);
    acc_cyc = cyc;
    if (expect_out) begin
      w = 0;
      while (sb.size() != 0 && w < 3000) begin
        @(posedge clk);
        w++;
      end
      if (sb.size() != 0) begin
        $display("FAIL drain_timeout actual %0d required 0 (cycle %0d)", sb.size(), cyc);
        $fatal(1, "output never drained");
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Identity kernel
    clr_vec();
    h_v[0] = 8'sd1;
    y_v[0] = 16'sd5; y_v[1] = -16'sd3; y_v[2] = 16'sd7;
    x_v[0] = 5; x_v[1] = -3; x_v[2] = 7;
    run_frame(0, 196, 1'b1);

    // Two-tap kernel, ramp output, y[8] discarded
    load_ramp();
    run_frame(0, 196, 1'b1);

    // h[0] == 0: all zeros, fast path
    clr_vec();
    h_v[1] = 8'sd3;
    y_v[0] = 16'sd9; y_v[1] = 16'sd4; y_v[5] = -16'sd20;
    run_frame(1, 1, 1'b1);

    // Inexact: 3 / 2
    clr_vec();
    h_v[0] = 8'sd2; y_v[0] = 16'sd3; x_v[0] = 1;
    run_frame(2, 196, 1'b1);

    // Overflow: 200 / 1 saturates
    clr_vec();
    h_v[0] = 8'sd1; y_v[0] = 16'sd200; x_v[0] = 127;
    run_frame(3, 196, 1'b1);

    // Negative dividend truncates toward zero: -7 / 3 = -2 remainder -1
    clr_vec();
    h_v[0] = 8'sd3; y_v[0] = -16'sd7; x_v[0] = -2;
    run_frame(2, 196, 1'b1);

    // Overflow and inexact together: overflow wins
    clr_vec();
    h_v[0] = 8'sd2; y_v[0] = 16'sd301; x_v[0] = 127;
    run_frame(3, 196, 1'b1);

    // Negative saturation: -300 / 1
    clr_vec();
    h_v[0] = 8'sd1; y_v[0] = -16'sd300; x_v[0] = -128;
    run_frame(3, 196, 1'b1);

    // Ramp again with downstream stalling every other cycle
    load_ramp();
    tog = 1'b1;
    run_frame(0, 196, 1'b1);
    tog = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during MAC of n = 4: nothing may come out
    load_ramp();
    run_frame(0, 0, 1'b0);
    repeat (91) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (300) @(posedge clk);
    #1;

    // Clean frame after the abandoned one
    load_ramp();
    run_frame(0, 196, 1'b1);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
